// File: rtl/lsu_pkg.sv
// Shared types and constants for the MEM-stage load/store initiator.
// Imported by lsu_lat_counter and lsu_mem_master.
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } lsu_state_e;

    localparam int         WORD_SHIFT = 2;
    localparam logic [1:0] ALIGN_MASK = 2'b11;

    // Kind of response the latched request will produce
    typedef enum logic [1:0] {
        RSP_NONE  = 2'd0,
        RSP_LOAD  = 2'd1,
        RSP_STORE = 2'd2,
        RSP_ERR   = 2'd3
    } rsp_type_e;

    function automatic logic is_misaligned(input logic [1:0] byte_off);
        return (byte_off & ALIGN_MASK) != 2'b00;
    endfunction

endpackage

// File: rtl/lsu_lat_counter.sv
// Loadable down-counter timing the memory access window; zero_o marks the
// last access cycle. Saturates at zero.
module lsu_lat_counter
    import lsu_pkg::*;
#(
    parameter int MEM_LAT = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load_i,
    input  logic dec_i,
    output logic zero_o
);

    localparam int                CNT_W    = $clog2(MEM_LAT + 1);
    localparam logic [CNT_W-1:0]  LOAD_VAL = CNT_W'(MEM_LAT - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = LOAD_VAL;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/lsu_mem_master.sv
// MEM-stage load/store initiator driving a word-indexed data memory.
// Define LSU_POST_WRITE_EN to ack stores in their first access cycle.
module lsu_mem_master
    import lsu_pkg::*;
#(
    parameter int MEM_LAT = 1,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_write_data,
    output logic              mem_memread,
    output logic              mem_memwrite,
    input  logic [DATA_W-1:0] mem_read_data,
    output logic              busy
);

    lsu_state_e        state_q, state_d;
    rsp_type_e         kind_q, kind_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              armed_q;
    logic              accept;
    logic              misaligned;
    logic              in_access;
    logic              cnt_zero;

    assign misaligned = is_misaligned(req_addr[1:0]);
    assign in_access  = (state_q == ACCESS);
    // armed_q keeps ready low until the first edge after reset release
    assign req_ready  = armed_q && (state_q != ACCESS);
    assign accept     = req_valid && req_ready;
    assign busy       = (state_q != IDLE);

    lsu_lat_counter #(
        .MEM_LAT (MEM_LAT)
    ) u_lat_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .load_i (accept && !misaligned),
        .dec_i  (in_access),
        .zero_o (cnt_zero)
    );

    always_comb begin
        state_d = state_q;
        kind_d  = kind_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        case (state_q)
            ACCESS: begin
                if (cnt_zero) begin
                    if (!we_q) begin
                        rdata_d = mem_read_data;
                    end
`ifdef LSU_POST_WRITE_EN
                    state_d = we_q ? IDLE : RESP;
`else
                    state_d = RESP;
`endif
                end
            end
            default: begin
                // IDLE and RESP share the same accept rules
                state_d = IDLE;
                if (accept) begin
                    rdata_d = '0;
                    if (misaligned) begin
                        state_d = RESP;
                        kind_d  = RSP_ERR;
                        we_d    = 1'b0;
                        wdata_d = '0;
                    end else begin
                        state_d = ACCESS;
                        kind_d  = req_we ? RSP_STORE : RSP_LOAD;
                        we_d    = req_we;
                        addr_d  = req_addr >> WORD_SHIFT;
                        wdata_d = req_we ? req_wdata : '0;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            kind_q  <= RSP_NONE;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            armed_q <= 1'b0;
        end else begin
            state_q <= state_d;
            kind_q  <= kind_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            armed_q <= 1'b1;
        end
    end

    // Memory side is decoded from state so an async reset drops it at once
    assign mem_memread    = in_access && !we_q;
    assign mem_memwrite   = in_access && we_q;
    assign mem_addr       = in_access ? addr_q : '0;
    assign mem_write_data = in_access ? wdata_q : '0;

    assign rsp_err   = (state_q == RESP) && (kind_q == RSP_ERR);
    assign rsp_rdata = ((state_q == RESP) && (kind_q == RSP_LOAD)) ? rdata_q : '0;

`ifdef LSU_POST_WRITE_EN
    logic first_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            first_q <= 1'b0;
        end else begin
            first_q <= accept && !misaligned;
        end
    end

    assign rsp_valid = (state_q == RESP) || (in_access && we_q && first_q);
`else
    assign rsp_valid = (state_q == RESP);
`endif

endmodule

// File: doc/lsu_mem_master.md
Name: lsu_mem_master

Overview:
- Load/store initiator for the MEM stage. Drives the existing word-indexed `data_memory` through its addr/write_data/memread/memwrite/read_data port set.
- Accepts one request at a time from the pipeline on a valid/ready handshake.
- Sequences the memory access over a fixed latency and returns a one-cycle response: load data, store ack, or misalignment error.

Parameters:
- MEM_LAT, 1, memory access cycles per request (>=1).
- ADDR_W, 32, byte-address width.
- DATA_W, 32, data width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  pipeline request valid.
- req_ready  out  1  block can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  DATA_W  store data.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_rdata  out  DATA_W  load data; 0 for stores and errors.
- rsp_err  out  1  misaligned request; qualifies rsp_valid.
- mem_addr  out  ADDR_W  word index = req_addr >> 2.
- mem_write_data  out  DATA_W  store data to memory.
- mem_memread  out  1  memory read enable.
- mem_memwrite  out  1  memory write enable.
- mem_read_data  in  DATA_W  memory read data.
- busy  out  1  state != IDLE.

Behaviour:
- Reset values (async, rst_n=0): all outputs 0, state=IDLE, counter=0, latched request cleared. req_ready=0 while rst_n low; req_ready=1 from the first clk edge after release.
- States and transitions:
  - IDLE: req_ready=1. On accept (req_valid & req_ready):
    - req_addr[1:0]!=0 -> RESP with error. No memory enable is ever asserted.
    - Otherwise latch we/addr/wdata, load counter=MEM_LAT-1, go to ACCESS.
  - ACCESS: drive the memory interface from the latched request.
    - mem_addr={2'b00,addr[ADDR_W-1:2]}.
    - mem_memread=!we, mem_memwrite=we, mem_write_data=wdata (0 for loads).
    - Counter decrements each cycle. When counter==0: loads capture mem_read_data into rsp_rdata; go to RESP.
  - RESP: rsp_valid=1 for exactly one cycle. rsp_err=1 only for the misaligned case. req_ready=1, so a new request may be accepted in RESP and follows the IDLE accept rules; otherwise return to IDLE.
- Memory enable rules:
  - mem_memread and mem_memwrite are never both 1.
  - Both are 0 outside ACCESS.
  - mem_addr and mem_write_data are stable for the whole ACCESS window.
- Latency: request accepted at edge N -> rsp_valid high in cycle N+MEM_LAT+1. Back-to-back throughput is one request per MEM_LAT+1 cycles.
- No response backpressure: rsp_valid is a pulse and the consumer must take it.
- req_ready=0 in ACCESS; req_valid is ignored there. Inputs need be stable only at the accept edge.
- Reset mid-ACCESS: enables drop immediately (async); the transaction is discarded and no rsp_valid is ever produced for it.
- Counter width: $clog2(MEM_LAT+1). For MEM_LAT=1, ACCESS lasts exactly one cycle.

Optional Feature:
- Macro: LSU_POST_WRITE_EN.
- Defined: stores are posted.
  - rsp_valid (ack) is asserted in the first ACCESS cycle.
  - The store then returns from ACCESS directly to IDLE, skipping RESP, so store throughput is one per MEM_LAT cycles plus accept.
  - Loads are unchanged.
- Undefined: stores ack in RESP exactly like loads.

Decomposition:
- Package lsu_pkg holds:
  - state typedef: IDLE, ACCESS, RESP.
  - WORD_SHIFT=2 and ALIGN_MASK=2'b11 constants.
  - Response-type encoding constants.
- One sub-module, lsu_lat_counter: loadable down-counter with a zero flag, parameterized by MEM_LAT.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles -> all outputs 0 and req_ready=0; after release req_ready=1 and busy=0.
- Aligned store, MEM_LAT=1: addr=0x4, wdata=0xFFFFFFFB, accept at edge N -> one cycle of mem_memwrite=1, mem_addr=1, mem_write_data=0xFFFFFFFB; rsp_valid=1, rsp_err=0 in cycle N+2.
- Load after that store: addr=0x4 (memory returns 0xFFFFFFFB) -> mem_memread=1, mem_addr=1; rsp_rdata=0xFFFFFFFB with rsp_valid.
- Misaligned load: addr=0x2 -> rsp_valid=1, rsp_err=1 the cycle after accept; mem_memread and mem_memwrite stay 0 throughout.
- Back-to-back, MEM_LAT=3: load 0x8 accepted at N; load 0xC accepted in its RESP cycle N+4 -> responses at N+4 and N+8; memread is never asserted in a RESP cycle.
- Reset mid-access, MEM_LAT=3: store 0x10, drop rst_n in the 2nd ACCESS cycle -> mem_memwrite falls without waiting for clk; no rsp_valid; next request after release behaves normally.
